mem_resp_ctrl: RTL and testbench

- Memory-side responder for the processor's data/instruction memory request interface; the other end of the Rd/Wr/Addr initiator in the fetch and memory stages.
- Accepts one word request at a time, holds Stall for a fixed latency, then pulses Done with read data or commits the write.
- Backed by an internal word array; drop-in for the multi-cycle memory used by the pipelined datapath.

---
 rtl/mem_resp_ctrl_pkg.sv | 18 +
 rtl/mem_resp_lfsr16.sv | 28 ++
 rtl/mem_resp_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_resp_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_ctrl_pkg.sv
// Shared definitions for the memory responder.
//   state_e      : FSM encoding (IDLE/BUSY/DONE)
//   DATA_W_DEF   : default word width
//   LFSR_SEED    : reset value of the jitter LFSR
//   LFSR_TAPS    : right-shift Galois feedback mask for taps 16,14,13,11
package mem_resp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEF = 16;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/mem_resp_lfsr16.sv
// 16-bit Galois LFSR, advances every cycle. Used only by the optional
// latency-jitter feature of mem_resp_ctrl.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (loads LFSR_SEED)
//   lfsr_o : current LFSR state
module mem_resp_lfsr16
  import mem_resp_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mem_resp_ctrl.sv
// Multi-cycle memory responder. Accepts one word request at a time in IDLE,
// stalls for LATENCY cycles, then pulses Done (with read data, or committing
// the write on that edge). Illegal requests (Rd&Wr, or odd Addr) pulse err.
// Optional: define MEM_RESP_JITTER_EN to add 0..3 extra cycles of
// LFSR-driven latency per request.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   Rd, Wr  : request strobes, sampled only in IDLE
//   Addr    : byte address (word index = Addr[DEPTH_LOG2:1], upper bits ignored)
//   DataIn  : write data, captured at acceptance
//   DataOut : read data during the Done cycle of a read, else 0
//   Done    : one-cycle completion pulse
//   Stall   : high while a request is in flight
//   err     : one-cycle pulse after an illegal request
module mem_resp_ctrl
  import mem_resp_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [15:0]       Addr,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              err
);

`ifdef MEM_RESP_JITTER_EN
  localparam int unsigned CNT_W = 5;
`else
  localparam int unsigned CNT_W = 4;
`endif
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, load_val;
  logic                    we_q, we_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic req_ok, req_bad;
  logic unused_addr;

  assign req_ok      = (Rd ^ Wr) & ~Addr[0];
  assign req_bad     = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign unused_addr = ^Addr[15:DEPTH_LOG2+1];

`ifdef MEM_RESP_JITTER_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  mem_resp_lfsr16 u_lfsr (
    .clk_i  (clk),
    .rst_i  (rst),
    .lfsr_o (lfsr)
  );

  assign load_val    = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
  assign unused_lfsr = ^lfsr[15:2];
`else
  assign load_val = CNT_W'(LATENCY - 1);
`endif

  // State and captured-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The counter holds the number of BUSY cycles still to
  // go; leaving BUSY when it is about to reach zero makes Done land exactly
  // LATENCY cycles after acceptance. A zero load skips BUSY entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_d = req_bad;
        if (req_ok) begin
          we_d    = Wr;
          idx_d   = Addr[DEPTH_LOG2:1];
          data_d  = DataIn;
          cnt_d   = load_val;
          state_d = (load_val == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Stall   = (state_q == BUSY);
    Done    = (state_q == DONE);
    err     = err_q;
    DataOut = '0;
    if (state_q == DONE && !we_q) DataOut = mem[idx_q];
  end

  // Array is not reset; a write commits only on the DONE edge
  always_ff @(posedge clk) begin
    if (state_q == DONE && we_q) mem[idx_q] <= data_q;
  end

endmodule

// File: tb/tb_mem_resp_ctrl.sv
module tb_mem_resp_ctrl;

  localparam int LAT = 3;
`ifdef MEM_RESP_JITTER_EN
  localparam int JIT = 3;
`else
  localparam int JIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Rd, Wr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Done, Stall, err;

  mem_resp_ctrl #(
    .DATA_W     (16),
    .DEPTH_LOG2 (8),
    .LATENCY    (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Rd      (Rd),
    .Wr      (Wr),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Done    (Done),
    .Stall   (Stall),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit [31:0] lat_seen = '0;

  typedef struct {
    bit          is_err;
    bit          is_read;
    logic [15:0] data;
    int          acc;     // cyc value right after the accepting edge
  } exp_t;

  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expectation per Done/err pulse
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst && (Done || err)) begin
      if (Done) done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: Done=%0b err=%0b required none (cyc %0d)", Done, err, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_is_err", {31'b0, err}, {31'b0, e.is_err});
        chk("resp_is_done", {31'b0, Done}, {31'b0, !e.is_err});
        if (e.is_err) begin
          chk("err_cycle", cyc, e.acc);
          chk("stall_on_err", {31'b0, Stall}, 32'd0);
        end else begin
          lat = cyc - e.acc + 1;
          if (lat >= 0 && lat < 32) lat_seen[lat] = 1'b1;
          chk("latency_in_range", {31'b0, (lat >= LAT && lat <= LAT + JIT)}, 32'd1);
          chk("stall_in_done", {31'b0, Stall}, 32'd0);
          chk(e.is_read ? "read_data" : "dataout_on_write", {16'b0, DataOut},
              {16'b0, (e.is_read ? e.data : 16'h0000)});
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d responses pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic push(input bit is_err, input bit is_read, input logic [15:0] d, input int acc);
    exp_t e;
    e.is_err  = is_err;
    e.is_read = is_read;
    e.data    = d;
    e.acc     = acc;
    sb.push_back(e);
  endtask

  // One request, held for exactly one accepting edge, then wait for response
  task automatic req(input bit r, input bit w, input logic [15:0] a,
                     input logic [15:0] d, input bit is_err, input logic [15:0] expd);
    @(negedge clk);
    Rd = r; Wr = w; Addr = a; DataIn = d;
    push(is_err, r && !is_err, expd, cyc + 1);
    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0;
    wait_idle();
  endtask

  int dc0;

  initial begin
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
    #1;
    chk("rst_outputs", {13'b0, Done, Stall, err, 16'b0} | {16'b0, DataOut}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", {13'b0, Done, Stall, err, DataOut}, 32'd0);
    end

    // Write BEEF, then read with explicit Stall timeline
    req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0010;
    push(1'b0, 1'b1, 16'hBEEF, cyc + 1);
    @(negedge clk);
    Rd = 1'b0;
    chk("stall_c1", {30'b0, Stall, Done}, 32'd2);
    @(negedge clk);
    chk("stall_c2", {30'b0, Stall, Done}, 32'd2);
    @(negedge clk);
    chk("done_c3", {30'b0, Stall, Done}, 32'd1);
    wait_idle();

    // Address wrap: 0x0200 aliases word 0
    req(1'b0, 1'b1, 16'h0200, 16'h1234, 1'b0, 16'h0);
    req(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0, 16'h1234);

    // Illegal requests
    req(1'b0, 1'b1, 16'h0002, 16'h7777, 1'b0, 16'h0);
    dc0 = done_cnt;
    req(1'b1, 1'b1, 16'h0004, 16'h0, 1'b1, 16'h0);
    req(1'b1, 1'b0, 16'h0003, 16'h0, 1'b1, 16'h0);
    req(1'b0, 1'b1, 16'h0003, 16'h9999, 1'b1, 16'h0);
    chk("no_done_on_illegal", done_cnt - dc0, 32'd0);
    req(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, 16'h7777);

    // Reset mid-write aborts with no update and no Done
    req(1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0, 16'h0);
    dc0 = done_cnt;
    @(negedge clk);
    Wr = 1'b1; Addr = 16'h0020; DataIn = 16'hAAAA;
    @(negedge clk);
    Wr = 1'b0;
    chk("busy_before_rst", {31'b0, Stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_clears", {29'b0, Stall, Done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("no_done_aborted", done_cnt - dc0, 32'd0);
    req(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h5555);

    // Wr toggled during BUSY/DONE of a read is ignored
    dc0 = done_cnt;
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0010;
    push(1'b0, 1'b1, 16'hBEEF, cyc + 1);
    for (int i = 0; i < LAT + JIT; i++) begin
      @(negedge clk);
      Rd = 1'b0;
      if (Done) break;
      Wr = ~Wr; DataIn = 16'hDEAD;
    end
    Wr = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("one_done_ignored_wr", done_cnt - dc0, 32'd1);
    req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'hBEEF);

    // Read presented the cycle after a write's Done sees the new data
    @(negedge clk);
    Wr = 1'b1; Addr = 16'h0040; DataIn = 16'hC0DE;
    push(1'b0, 1'b0, 16'h0, cyc + 1);
    @(negedge clk);
    Wr = 1'b0;
    for (int i = 0; i < 20 && !Done; i++) @(negedge clk);
    chk("wr_done_seen", {31'b0, Done}, 32'd1);
    Rd = 1'b1;  // ignored on the DONE edge, accepted on the next (IDLE) edge
    push(1'b0, 1'b1, 16'hC0DE, cyc + 2);
    @(negedge clk);
    @(negedge clk);
    Rd = 1'b0;
    wait_idle();

    // Repeated reads: latency range (and spread when jitter is built in)
    lat_seen = '0;
    for (int i = 0; i < 100; i++) req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'hBEEF);
`ifdef MEM_RESP_JITTER_EN
    chk("jitter_distinct", {31'b0, ($countones(lat_seen) >= 2)}, 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
